load_store_unit: RTL and testbench

//  Byte-addressed load/store front end placed directly upstream of data_memory (word-indexed, 32-bit).

---
 rtl/load_store_unit.sv | 185 ++++++++++++++++++
 tb/tb_load_store_unit.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Byte-addressed load/store front end for a word-indexed 32-bit data memory.
// Sub-word stores are read-modify-write; loads are sign- or zero-extended.
module load_store_unit #(
    parameter int unsigned MEM_WORDS = 32
) (
    input  logic        clk_i,
    input  logic        reset_ni,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [1:0]  req_size_i,
    input  logic        req_unsigned_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    output logic        resp_valid_o,
    input  logic        resp_ready_i,
    output logic [31:0] resp_rdata_o,
    output logic        resp_misaligned_o,
    output logic        resp_fault_o,
    output logic        mem_write_o,
    output logic [1:0]  mem_size_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic [31:0] mem_rdata_i
);

    typedef enum logic [2:0] {
        StIdle,
        StRead,
        StData,
        StWrite,
        StResp
    } state_e;

    state_e      state_q, state_d;
    logic        we_q, we_d;
    logic [1:0]  size_q, size_d;
    logic        uns_q, uns_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        mis_q, mis_d;
    logic        fault_q, fault_d;

    logic        req_mis;
    logic        req_fault;
    logic [31:0] req_word_idx;
    logic [4:0]  byte_sh;
    logic [4:0]  half_sh;
    logic [7:0]  byte_val;
    logic [15:0] half_val;
    logic [31:0] load_ext;
    logic [31:0] merged;

    // Request decode: alignment and range are judged on the live request in IDLE.
    always_comb begin
        req_mis = 1'b0;
        case (req_size_i)
            2'b00:   req_mis = 1'b0;
            2'b01:   req_mis = req_addr_i[0];
            2'b10:   req_mis = |req_addr_i[1:0];
            default: req_mis = 1'b1;
        endcase
        req_word_idx = {2'b00, req_addr_i[31:2]};
        req_fault    = (req_word_idx >= MEM_WORDS);
    end

    // Lane selection for the registered request, little-endian.
    always_comb begin
        byte_sh  = {addr_q[1:0], 3'b000};
        half_sh  = {addr_q[1], 4'b0000};
        byte_val = mem_rdata_i[byte_sh +: 8];
        half_val = mem_rdata_i[half_sh +: 16];

        load_ext = mem_rdata_i;
        case (size_q)
            2'b00:   load_ext = uns_q ? {24'b0, byte_val} : {{24{byte_val[7]}}, byte_val};
            2'b01:   load_ext = uns_q ? {16'b0, half_val} : {{16{half_val[15]}}, half_val};
            default: load_ext = mem_rdata_i;
        endcase

        merged = mem_rdata_i;
        if (size_q == 2'b00) begin
            merged[byte_sh +: 8] = wdata_q[7:0];
        end else begin
            merged[half_sh +: 16] = wdata_q[15:0];
        end
    end

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        size_d  = size_q;
        uns_d   = uns_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        mis_d   = mis_q;
        fault_d = fault_q;

        case (state_q)
            StIdle: begin
                if (req_valid_i) begin
                    we_d    = req_we_i;
                    size_d  = req_size_i;
                    uns_d   = req_unsigned_i;
                    addr_d  = req_addr_i;
                    wdata_d = req_wdata_i;
                    rdata_d = 32'h0;
                    mis_d   = req_mis;
                    // Misalignment takes precedence over an out-of-range index.
                    fault_d = !req_mis && req_fault;
                    if (req_mis || req_fault) begin
                        state_d = StResp;
                    end else if (!req_we_i || (req_size_i != 2'b10)) begin
                        state_d = StRead;
                    end else begin
                        state_d = StWrite;
                    end
                end
            end
            StRead: begin
                state_d = StData;
            end
            StData: begin
                if (we_q) begin
                    wdata_d = merged;
                    state_d = StWrite;
                end else begin
                    rdata_d = load_ext;
                    state_d = StResp;
                end
            end
            StWrite: begin
                state_d = StResp;
            end
            StResp: begin
                if (resp_ready_i) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q <= StIdle;
            we_q    <= 1'b0;
            size_q  <= 2'b00;
            uns_q   <= 1'b0;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            rdata_q <= 32'h0;
            mis_q   <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            mis_q   <= mis_d;
            fault_q <= fault_d;
        end
    end

    // Ready is gated by reset so every output except mem_size_o reads 0 while in reset.
    always_comb begin
        req_ready_o       = reset_ni && (state_q == StIdle);
        resp_valid_o      = (state_q == StResp);
        resp_rdata_o      = rdata_q;
        resp_misaligned_o = mis_q;
        resp_fault_o      = fault_q;
        mem_write_o       = (state_q == StWrite);
        mem_size_o        = 2'b10;
        mem_addr_o        = {2'b00, addr_q[31:2]};
        mem_wdata_o       = wdata_q;
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a registered-read word memory model
// and a response scoreboard fed from a reference model of the byte-addressed memory.
module tb_load_store_unit;

    logic        clk_i;
    logic        reset_ni;
    logic        req_valid_i;
    logic        req_ready_o;
    logic        req_we_i;
    logic [1:0]  req_size_i;
    logic        req_unsigned_i;
    logic [31:0] req_addr_i;
    logic [31:0] req_wdata_i;
    logic        resp_valid_o;
    logic        resp_ready_i;
    logic [31:0] resp_rdata_o;
    logic        resp_misaligned_o;
    logic        resp_fault_o;
    logic        mem_write_o;
    logic [1:0]  mem_size_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic [31:0] mem_rdata_i;

    load_store_unit #(.MEM_WORDS(32)) dut (
        .clk_i             (clk_i),
        .reset_ni          (reset_ni),
        .req_valid_i       (req_valid_i),
        .req_ready_o       (req_ready_o),
        .req_we_i          (req_we_i),
        .req_size_i        (req_size_i),
        .req_unsigned_i    (req_unsigned_i),
        .req_addr_i        (req_addr_i),
        .req_wdata_i       (req_wdata_i),
        .resp_valid_o      (resp_valid_o),
        .resp_ready_i      (resp_ready_i),
        .resp_rdata_o      (resp_rdata_o),
        .resp_misaligned_o (resp_misaligned_o),
        .resp_fault_o      (resp_fault_o),
        .mem_write_o       (mem_write_o),
        .mem_size_o        (mem_size_o),
        .mem_addr_o        (mem_addr_o),
        .mem_wdata_o       (mem_wdata_o),
        .mem_rdata_i       (mem_rdata_i)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // data_memory stand-in: whole-word writes, read data one cycle after the address
    logic [31:0] mem [32];
    always @(posedge clk_i) begin
        if (mem_write_o) mem[mem_addr_o[4:0]] <= mem_wdata_o;
        mem_rdata_i <= mem[mem_addr_o[4:0]];
    end

    int          wr_count;
    logic [31:0] last_wr_addr;
    logic [31:0] last_wr_data;
    always @(negedge clk_i) begin
        if (reset_ni && mem_write_o) begin
            wr_count     <= wr_count + 1;
            last_wr_addr <= mem_addr_o;
            last_wr_data <= mem_wdata_o;
        end
    end

    typedef struct {
        logic [31:0] rdata;
        logic        mis;
        logic        fault;
        int          lat;
        int          writes;
        logic [31:0] wr_idx;
        logic [31:0] wr_word;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] ref_mem [32];
    int          n_assert;
    int          n_fail;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata, output exp_t e);
        logic [31:0] w;
        logic [31:0] sel;
        int          sh;
        e.rdata   = 32'h0;
        e.mis     = (size == 2'b11) || (size == 2'b01 && addr[0]) ||
                    (size == 2'b10 && addr[1:0] != 2'b00);
        e.fault   = !e.mis && (addr[31:2] >= 30'd32);
        e.writes  = 0;
        e.wr_idx  = 32'h0;
        e.wr_word = 32'h0;
        if (e.mis || e.fault) begin
            e.lat = 1;
            return;
        end
        w  = ref_mem[addr[6:2]];
        sh = (size == 2'b00) ? int'(addr[1:0]) * 8 : int'(addr[1]) * 16;
        if (!we) begin
            e.lat = 3;
            sel   = w >> sh;
            if (size == 2'b00) e.rdata = uns ? (sel & 32'hFF) : 32'(signed'(sel[7:0]));
            else if (size == 2'b01) e.rdata = uns ? (sel & 32'hFFFF) : 32'(signed'(sel[15:0]));
            else e.rdata = w;
        end else begin
            if (size == 2'b10) begin
                e.lat = 2;
                w     = wdata;
            end else begin
                e.lat = 4;
                sel   = (size == 2'b00) ? 32'hFF : 32'hFFFF;
                w     = (w & ~(sel << sh)) | ((wdata & sel) << sh);
            end
            ref_mem[addr[6:2]] = w;
            e.writes  = 1;
            e.wr_idx  = {27'b0, addr[6:2]};
            e.wr_word = w;
        end
    endtask

    task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input int stall, output logic [31:0] obs);
        exp_t e;
        int   cyc;
        int   wr_before;
        model(we, size, uns, addr, wdata, e);
        sb.push_back(e);
        wr_before      = wr_count;
        resp_ready_i   = (stall == 0);
        req_valid_i    = 1'b1;
        req_we_i       = we;
        req_size_i     = size;
        req_unsigned_i = uns;
        req_addr_i     = addr;
        req_wdata_i    = wdata;
        check("req_ready_idle", 32'(req_ready_o), 32'd1);
        @(posedge clk_i); #1;
        req_valid_i = 1'b0;
        req_wdata_i = 32'h0;
        cyc = 1;
        while (!resp_valid_o && cyc < 20) begin
            @(posedge clk_i); #1;
            cyc++;
        end
        e = sb.pop_front();
        check("latency", 32'(cyc), 32'(e.lat));
        check("rdata", resp_rdata_o, e.rdata);
        check("misaligned", 32'(resp_misaligned_o), 32'(e.mis));
        check("fault", 32'(resp_fault_o), 32'(e.fault));
        check("mem_writes", 32'(wr_count - wr_before), 32'(e.writes));
        check("mem_size", 32'(mem_size_o), 32'd2);
        if (e.writes != 0) begin
            check("wr_idx", last_wr_addr, e.wr_idx);
            check("wr_word", last_wr_data, e.wr_word);
        end
        obs = resp_rdata_o;
        for (int i = 0; i < stall; i++) begin
            check("stall_valid", 32'(resp_valid_o), 32'd1);
            check("stall_rdata", resp_rdata_o, e.rdata);
            check("stall_ready", 32'(req_ready_o), 32'd0);
            @(posedge clk_i); #1;
        end
        if (stall != 0) begin
            check("stall_end_valid", 32'(resp_valid_o), 32'd1);
            resp_ready_i = 1'b1;
        end
        @(posedge clk_i); #1;
        check("back_idle_valid", 32'(resp_valid_o), 32'd0);
        check("back_idle_ready", 32'(req_ready_o), 32'd1);
    endtask

    logic [31:0] r;
    int          wr_snap;

    initial begin
        n_assert       = 0;
        n_fail         = 0;
        wr_count       = 0;
        last_wr_addr   = 32'h0;
        last_wr_data   = 32'h0;
        reset_ni       = 1'b0;
        req_valid_i    = 1'b0;
        req_we_i       = 1'b0;
        req_size_i     = 2'b00;
        req_unsigned_i = 1'b0;
        req_addr_i     = 32'h0;
        req_wdata_i    = 32'h0;
        resp_ready_i   = 1'b1;
        for (int i = 0; i < 32; i++) begin
            mem[i]     = 32'h0;
            ref_mem[i] = 32'h0;
        end

        #12;
        check("rst_req_ready", 32'(req_ready_o), 32'd0);
        check("rst_resp_valid", 32'(resp_valid_o), 32'd0);
        check("rst_mem_write", 32'(mem_write_o), 32'd0);
        check("rst_mem_size", 32'(mem_size_o), 32'd2);
        check("rst_mem_addr", mem_addr_o, 32'h0);
        check("rst_rdata", resp_rdata_o, 32'h0);
        @(negedge clk_i);
        reset_ni = 1'b1;
        @(posedge clk_i); #1;
        check("idle_ready", 32'(req_ready_o), 32'd1);

        // word store, sub-word RMW, readback
        do_req(1'b1, 2'b10, 1'b0, 32'h08, 32'hDEADBEEF, 0, r);
        check("sw_addr", last_wr_addr, 32'd2);
        check("sw_data", last_wr_data, 32'hDEADBEEF);
        do_req(1'b1, 2'b00, 1'b0, 32'h09, 32'hAABBCC55, 0, r);
        check("sb_merge", last_wr_data, 32'hDEAD55EF);
        do_req(1'b0, 2'b10, 1'b0, 32'h08, 32'h0, 0, r);
        check("lw_after_sb", r, 32'hDEAD55EF);

        // extension
        do_req(1'b1, 2'b10, 1'b0, 32'h08, 32'h80FF0000, 0, r);
        do_req(1'b0, 2'b00, 1'b0, 32'h0B, 32'h0, 0, r);
        check("lb", r, 32'hFFFFFF80);
        do_req(1'b0, 2'b00, 1'b1, 32'h0B, 32'h0, 0, r);
        check("lbu", r, 32'h00000080);
        do_req(1'b0, 2'b01, 1'b0, 32'h0A, 32'h0, 0, r);
        check("lh", r, 32'hFFFF80FF);
        do_req(1'b0, 2'b01, 1'b1, 32'h0A, 32'h0, 0, r);
        check("lhu", r, 32'h000080FF);
        do_req(1'b0, 2'b10, 1'b1, 32'h08, 32'h0, 0, r);
        check("lw_ignores_uns", r, 32'h80FF0000);
        do_req(1'b1, 2'b01, 1'b0, 32'h08, 32'hFFFF1234, 0, r);
        do_req(1'b1, 2'b00, 1'b0, 32'h0B, 32'h000000A7, 0, r);
        do_req(1'b0, 2'b10, 1'b0, 32'h08, 32'h0, 0, r);
        check("lw_after_sh_sb", r, 32'hA7FF1234);

        // errors and range boundary
        do_req(1'b0, 2'b01, 1'b0, 32'h01, 32'h0, 0, r);
        do_req(1'b1, 2'b10, 1'b0, 32'h06, 32'h12345678, 0, r);
        do_req(1'b1, 2'b11, 1'b0, 32'h04, 32'h12345678, 0, r);
        do_req(1'b1, 2'b10, 1'b0, 32'h80, 32'h12345678, 0, r);
        do_req(1'b0, 2'b01, 1'b0, 32'h81, 32'h0, 0, r);
        do_req(1'b1, 2'b10, 1'b0, 32'h7C, 32'hCAFEF00D, 0, r);
        do_req(1'b0, 2'b00, 1'b0, 32'h7F, 32'h0, 0, r);
        check("lb_last_word", r, 32'hFFFFFFCA);

        // response back-pressure
        do_req(1'b0, 2'b10, 1'b0, 32'h08, 32'h0, 5, r);
        check("stalled_lw", r, 32'hA7FF1234);

        // reset during DATA of a half store
        do_req(1'b1, 2'b10, 1'b0, 32'h10, 32'h11223344, 0, r);
        wr_snap        = wr_count;
        req_valid_i    = 1'b1;
        req_we_i       = 1'b1;
        req_size_i     = 2'b01;
        req_unsigned_i = 1'b0;
        req_addr_i     = 32'h12;
        req_wdata_i    = 32'h0000AAAA;
        @(posedge clk_i); #1;
        req_valid_i = 1'b0;
        @(posedge clk_i); #1;
        reset_ni = 1'b0;
        #1;
        check("rst6_ready", 32'(req_ready_o), 32'd0);
        check("rst6_valid", 32'(resp_valid_o), 32'd0);
        check("rst6_write", 32'(mem_write_o), 32'd0);
        check("rst6_addr", mem_addr_o, 32'h0);
        check("rst6_wdata", mem_wdata_o, 32'h0);
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        reset_ni = 1'b1;
        repeat (4) @(posedge clk_i);
        #1;
        check("rst6_no_write", 32'(wr_count - wr_snap), 32'd0);
        do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 0, r);
        check("rst6_old_value", r, 32'h11223344);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
